uarecv: RTL and testbench
=========================

UARECV -- requirements
Module: uarecv

Interface
REQ-001 Parameter: OSR, 16, number of en ticks per bit period; even value, 8..64.
REQ-002 Port: clk  input  1  master (global) clock; all state changes on posedge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  one-clk-wide tick at OSR x baud rate; qualifies all bit timing.
REQ-005 Port: serial_in  input  1  asynchronous serial line; idle high; frame = start 0, 8 data bits LSB first, stop 1.
REQ-006 Port: ack  input  1  consumer acknowledge; clears rdy and overrun.
REQ-007 Port: data_out  output  8  last received byte.
REQ-008 Port: rdy  output  1  high when data_out holds an unacknowledged valid byte.
REQ-009 Port: frame_err  output  1  one-clk pulse when a stop bit samples 0.
REQ-010 Port: overrun  output  1  sticky; a byte completed while rdy was already high.

Function
REQ-011 serial_in SHALL pass through a 2-flop synchronizer clocked every clk; "line" below means the synchronizer output.
REQ-012 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-013 Tick counter and bit counter SHALL change only on clk edges where en=1; all state transitions SHALL occur only on such edges.
REQ-014 IDLE: on a tick with line=0, go to START and clear the tick counter; this is the detect tick.
REQ-015 START: the line SHALL be sampled on the (OSR/2)th tick after the detect tick; 0 -> DATA, 1 -> IDLE (false start, no output change).
REQ-016 DATA: each data bit SHALL be sampled OSR ticks after the previous sample and shifted in LSB first; after the 8th bit, go to STOP.
REQ-017 STOP: the line SHALL be sampled OSR ticks after bit 7.
REQ-018 Stop=1: data_out SHALL load the assembled byte and rdy SHALL be 1 from the next clk edge; go to IDLE.
REQ-019 Stop=0: frame_err SHALL pulse for exactly one clk; data_out and rdy unchanged; go to BREAK.
REQ-020 BREAK: remain until a tick with line=1, then go to IDLE; no start detection in BREAK.
REQ-021 ack=1 SHALL clear rdy and overrun on the next clk edge.
REQ-022 Byte completes while rdy=1 and ack=0: data_out SHALL be overwritten with the new byte, rdy stays 1, overrun SHALL set.
REQ-023 ack=1 on the same edge that a byte completes: the new byte SHALL win (rdy=1, overrun=0).
REQ-024 ack SHALL have no effect on the receive state machine; reception continues regardless of rdy.
REQ-025 en held low SHALL freeze all state except rdy/overrun/ack handling and the synchronizer.
REQ-026 Latency: rdy SHALL rise one clk after the en tick sampling the stop bit.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, counters=0, shift register=0, data_out=8'h00, rdy=0, frame_err=0, overrun=0, synchronizer=1'b1.
REQ-028 Reset mid-frame SHALL abandon the frame with no output; after release, reception resumes with the next falling edge seen in IDLE.

Verification
REQ-029 OSR=16, en every clk, frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with stop=1 -> data_out=8'hA5, rdy=1 one clk after stop sample, frame_err never high.
REQ-030 Low glitch of 4 ticks on idle line -> START aborts to IDLE; rdy=0, data_out unchanged, next frame 0x3C received correctly.
REQ-031 Frame 0x55 with stop=0, line then held low 40 ticks, then high, then frame 0x0F -> one frame_err pulse, rdy=0 after the first frame, then data_out=8'h0F, rdy=1.
REQ-032 Frames 0x11 then 0x22 with no ack -> data_out=8'h22, rdy=1, overrun=1; one-clk ack -> rdy=0, overrun=0.
REQ-033 Assert rst_n=0 during bit 3 of 0x99, release, send 0xC3 -> no output for 0x99; data_out=8'hC3, rdy=1.
REQ-034 en every 4th clk, back-to-back frames 0x00 and 0xFF with ack after each -> both bytes received, overrun=0, frame_err=0.

Source files
------------

// File: rtl/uarecv.sv
`default_nettype none
// ============================================================================
// Module      : uarecv
// Description : Oversampling 8N1 UART receiver with ready/ack handshake,
//               frame-error pulse, break hold-off and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uarecv #(
   parameter int OSR = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       serial_in,
   input  logic       ack,
   output logic [7:0] data_out,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int              c_TW        = $clog2(OSR);
   localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(OSR / 2 - 1);
   localparam logic [c_TW-1:0] c_FULL_LAST = c_TW'(OSR - 1);
   localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_TW-1:0] r_tick, w_tick_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_sync1, r_sync2;
   logic            w_line;
   logic            w_byte_done;
   logic            w_stop_err;

   assign w_line = r_sync2;

   // Synchronizer idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_byte_done = 1'b0;
      w_stop_err  = 1'b0;
      if (en) begin
         case (r_state)
            S_IDLE: begin
               if (!w_line) begin
                  w_state_nxt = S_START;
                  w_tick_nxt  = '0;
               end
            end
            S_START: begin
               if (r_tick == c_HALF_LAST) begin
                  w_tick_nxt  = '0;
                  w_bit_nxt   = '0;
                  w_state_nxt = w_line ? S_IDLE : S_DATA;
               end else begin
                  w_tick_nxt = r_tick + c_TICK_ONE;
               end
            end
            S_DATA: begin
               if (r_tick == c_FULL_LAST) begin
                  w_tick_nxt  = '0;
                  w_shift_nxt = {w_line, r_shift[7:1]};
                  if (r_bit == 3'd7) begin
                     w_state_nxt = S_STOP;
                  end else begin
                     w_bit_nxt = r_bit + 3'd1;
                  end
               end else begin
                  w_tick_nxt = r_tick + c_TICK_ONE;
               end
            end
            S_STOP: begin
               if (r_tick == c_FULL_LAST) begin
                  w_tick_nxt = '0;
                  if (w_line) begin
                     w_byte_done = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_stop_err  = 1'b1;
                     w_state_nxt = S_BREAK;
                  end
               end else begin
                  w_tick_nxt = r_tick + c_TICK_ONE;
               end
            end
            S_BREAK: begin
               if (w_line) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // A completing byte takes priority over a simultaneous ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out  <= 8'h00;
         rdy       <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= w_stop_err;
         if (w_byte_done) begin
            data_out <= r_shift;
            rdy      <= 1'b1;
            overrun  <= ack ? 1'b0 : (overrun | rdy);
         end else if (ack) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uarecv.sv
`default_nettype none
// ============================================================================
// Module      : tb_uarecv
// Description : Self-checking bench for uarecv against a tick-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uarecv;

   localparam int OSR = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       serial_in = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] data_out;
   logic       rdy;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad = 0;
   int en_div = 1;
   int cyc = 0;
   int ferr_cnt = 0;
   bit auto_ack = 1'b0;
   logic [7:0] acked_q[$];

   uarecv #(.OSR(OSR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .serial_in (serial_in),
      .ack       (ack),
      .data_out  (data_out),
      .rdy       (rdy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         en = ((cyc % en_div) == 0);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: samples fall at fixed tick offsets from the detect tick
   logic [1:0] m_sync = 2'b11;
   int         m_tickn = 0;
   int         m_det = 0;
   bit         m_active = 1'b0;
   bit         m_brk = 1'b0;
   logic [7:0] m_asm = 8'h00;
   logic [7:0] exp_data = 8'h00;
   logic       exp_rdy = 1'b0;
   logic       exp_ovr = 1'b0;
   logic       exp_ferr = 1'b0;

   always @(posedge clk) begin : p_model
      logic line;
      bit   done;
      bit   err;
      int   d;
      int   k;
      done = 1'b0;
      err  = 1'b0;
      line = m_sync[1];
      if (!rst_n) begin
         m_sync   = 2'b11;
         m_tickn  = 0;
         m_active = 1'b0;
         m_brk    = 1'b0;
         exp_data = 8'h00;
         exp_rdy  = 1'b0;
         exp_ovr  = 1'b0;
         exp_ferr = 1'b0;
      end else begin
         if (en) begin
            m_tickn++;
            if (m_brk) begin
               if (line) m_brk = 1'b0;
            end else if (!m_active) begin
               if (!line) begin
                  m_active = 1'b1;
                  m_det    = m_tickn;
               end
            end else begin
               d = m_tickn - m_det;
               if (d >= OSR / 2 && ((d - OSR / 2) % OSR) == 0) begin
                  k = (d - OSR / 2) / OSR;
                  if (k == 0) begin
                     if (line) m_active = 1'b0;
                  end else if (k <= 8) begin
                     m_asm[k-1] = line;
                  end else begin
                     m_active = 1'b0;
                     if (line) done = 1'b1;
                     else begin
                        err   = 1'b1;
                        m_brk = 1'b1;
                     end
                  end
               end
            end
         end
         exp_ferr = err;
         if (done) begin
            exp_ovr  = !ack && (exp_ovr || exp_rdy);
            exp_rdy  = 1'b1;
            exp_data = m_asm;
         end else if (ack) begin
            exp_rdy = 1'b0;
            exp_ovr = 1'b0;
         end
         m_sync = {m_sync[0], serial_in};
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_data_out", data_out, 8'h00);
         chk("rst_rdy", {7'b0, rdy}, 8'h00);
         chk("rst_frame_err", {7'b0, frame_err}, 8'h00);
         chk("rst_overrun", {7'b0, overrun}, 8'h00);
      end else begin
         chk("data_out", data_out, exp_data);
         chk("rdy", {7'b0, rdy}, {7'b0, exp_rdy});
         chk("frame_err", {7'b0, frame_err}, {7'b0, exp_ferr});
         chk("overrun", {7'b0, overrun}, {7'b0, exp_ovr});
      end
      if (frame_err === 1'b1) ferr_cnt++;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (auto_ack && rdy === 1'b1) begin
            acked_q.push_back(data_out);
            @(posedge clk);
            #1 ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
         end
      end
   end

   task automatic ticks(input int n);
      repeat (n * en_div) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      ticks(n);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      serial_in = 1'b0;
      ticks(OSR);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         ticks(OSR);
      end
      serial_in = stop;
      ticks(OSR);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
   endtask

   initial begin
      int f0;
      logic [7:0] v;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdy", {7'b0, rdy}, 8'h00);
      chk("reset_data", data_out, 8'h00);
      rst_n = 1'b1;
      idle(20);

      // Basic frame
      send(8'hA5, 1'b1);
      idle(20);
      chk("a5_data", data_out, 8'hA5);
      chk("a5_rdy", {7'b0, rdy}, 8'h01);
      chk("a5_no_ferr", 8'(ferr_cnt), 8'h00);
      ack_pulse();
      chk("a5_ack_rdy", {7'b0, rdy}, 8'h00);

      // Glitch shorter than half a bit
      serial_in = 1'b0;
      ticks(4);
      idle(30);
      chk("glitch_rdy", {7'b0, rdy}, 8'h00);
      chk("glitch_data", data_out, 8'hA5);
      send(8'h3C, 1'b1);
      idle(20);
      chk("3c_data", data_out, 8'h3C);
      chk("3c_rdy", {7'b0, rdy}, 8'h01);
      ack_pulse();

      // Framing error followed by break
      f0 = ferr_cnt;
      send(8'h55, 1'b0);
      ticks(40);
      idle(20);
      chk("55_ferr_count", 8'(ferr_cnt - f0), 8'h01);
      chk("55_rdy", {7'b0, rdy}, 8'h00);
      chk("55_data", data_out, 8'h3C);
      send(8'h0F, 1'b1);
      idle(20);
      chk("0f_data", data_out, 8'h0F);
      chk("0f_rdy", {7'b0, rdy}, 8'h01);
      ack_pulse();

      // Overrun
      send(8'h11, 1'b1);
      idle(5);
      send(8'h22, 1'b1);
      idle(20);
      chk("ovr_data", data_out, 8'h22);
      chk("ovr_rdy", {7'b0, rdy}, 8'h01);
      chk("ovr_flag", {7'b0, overrun}, 8'h01);
      ack_pulse();
      chk("ovr_ack_rdy", {7'b0, rdy}, 8'h00);
      chk("ovr_ack_flag", {7'b0, overrun}, 8'h00);

      // Reset during bit 3 of 0x99
      v = 8'h99;
      serial_in = 1'b0;
      ticks(OSR);
      for (int i = 0; i < 3; i++) begin
         serial_in = v[i];
         ticks(OSR);
      end
      serial_in = v[3];
      ticks(OSR / 2);
      rst_n = 1'b0;
      serial_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(20);
      chk("rst_mid_rdy", {7'b0, rdy}, 8'h00);
      chk("rst_mid_data", data_out, 8'h00);
      send(8'hC3, 1'b1);
      idle(20);
      chk("c3_data", data_out, 8'hC3);
      chk("c3_rdy", {7'b0, rdy}, 8'h01);
      ack_pulse();

      // Slow tick rate, back-to-back frames, acked by the helper process
      en_div = 4;
      idle(10);
      acked_q.delete();
      f0 = ferr_cnt;
      auto_ack = 1'b1;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      idle(20);
      auto_ack = 1'b0;
      chk("b2b_count", 8'(acked_q.size()), 8'h02);
      if (acked_q.size() >= 2) begin
         chk("b2b_first", acked_q[0], 8'h00);
         chk("b2b_second", acked_q[1], 8'hFF);
      end
      chk("b2b_overrun", {7'b0, overrun}, 8'h00);
      chk("b2b_ferr", 8'(ferr_cnt - f0), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
